// File: rtl/registered_ripple_carry_adder.sv
// Registered ripple-carry adder: A + B + Cin through a bit-serial carry chain,
// with sum, unsigned carry (CF) and signed overflow (OF) captured one cycle
// after a qualified input. Baseline for the carry-lookahead comparison.
module registered_ripple_carry_adder #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic                  Cin,
    output logic [DATA_WIDTH-1:0] S,
    output logic                  CF,
    output logic                  OF,
    output logic                  out_valid
);

    // c[i] is the carry into bit i; c[DATA_WIDTH] is the carry out of the MSB.
    logic [DATA_WIDTH:0]   c;
    logic [DATA_WIDTH-1:0] sum;
    logic                  cf;
    logic                  of;

    logic [DATA_WIDTH-1:0] s_q, s_d;
    logic                  cf_q, cf_d;
    logic                  of_q, of_d;
    logic                  valid_q, valid_d;

    // Ripple chain: each iteration is one full-adder cell fed by the previous carry.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = Cin;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            sum[i]   = A[i] ^ B[i] ^ c[i];
            c[i+1]   = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
    end

    // Flags from the top of the chain; for a 1-bit adder c[DATA_WIDTH-1] is Cin.
    always_comb begin
        cf = c[DATA_WIDTH];
        of = c[DATA_WIDTH] ^ c[DATA_WIDTH-1];
    end

    // Next state: load on a qualified edge, otherwise hold the last result.
    always_comb begin
        s_d     = s_q;
        cf_d    = cf_q;
        of_d    = of_q;
        valid_d = in_valid;
        if (in_valid) begin
            s_d  = sum;
            cf_d = cf;
            of_d = of;
        end
    end

    // Output register; reset clears everything, including a pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= '0;
            cf_q    <= 1'b0;
            of_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            s_q     <= s_d;
            cf_q    <= cf_d;
            of_q    <= of_d;
            valid_q <= valid_d;
        end
    end

    assign S         = s_q;
    assign CF        = cf_q;
    assign OF        = of_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_registered_ripple_carry_adder.sv
// Bench for registered_ripple_carry_adder: directed literal cases plus a
// randomized sweep, all checked against an arithmetic model every cycle.
module tb_registered_ripple_carry_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cf;
    logic         of;
    logic         out_valid;

    int n_checks = 0;
    int n_pass   = 0;
    bit model_on = 1'b0;

    // Model state: what the outputs must hold, from plain arithmetic.
    logic [W-1:0] exp_s;
    logic         exp_cf;
    logic         exp_of;
    logic         exp_ov;

    registered_ripple_carry_adder #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .S         (s),
        .CF        (cf),
        .OF        (of),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    endtask

    // Behavioural reference: 9-bit sum, signed overflow from operand/result signs.
    always @(posedge clk or posedge rst) begin
        logic [W:0] full;
        if (rst) begin
            exp_s  = '0;
            exp_cf = 1'b0;
            exp_of = 1'b0;
            exp_ov = 1'b0;
        end else begin
            exp_ov = in_valid;
            if (in_valid) begin
                full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                exp_s  = full[W-1:0];
                exp_cf = full[W];
                exp_of = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (model_on && !rst) begin
            chk("model_S", {24'd0, s}, {24'd0, exp_s});
            chk("model_CF", {31'd0, cf}, {31'd0, exp_cf});
            chk("model_OF", {31'd0, of}, {31'd0, exp_of});
            chk("model_out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        end
    end

    // Drive one cycle's inputs just after a falling edge.
    task automatic step(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic tv);
        @(negedge clk);
        a        = ta;
        b        = tb_;
        cin      = tc;
        in_valid = tv;
    endtask

    // Apply a valid input and check the registered result against literals.
    task automatic lit(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic [W-1:0] es, input logic ecf,
                       input logic eof);
        step(ta, tb_, tc, 1'b1);
        @(posedge clk);
        #1;
        chk({name, "_S"}, {24'd0, s}, {24'd0, es});
        chk({name, "_CF"}, {31'd0, cf}, {31'd0, ecf});
        chk({name, "_OF"}, {31'd0, of}, {31'd0, eof});
        chk({name, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        // Pin the model to the same literals.
        chk({name, "_model_S"}, {24'd0, exp_s}, {24'd0, es});
        chk({name, "_model_CF"}, {31'd0, exp_cf}, {31'd0, ecf});
        chk({name, "_model_OF"}, {31'd0, exp_of}, {31'd0, eof});
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        #2;
        // Reset between edges must clear outputs immediately.
        rst = 1'b1;
        #1;
        chk("rst_S", {24'd0, s}, 32'd0);
        chk("rst_CF", {31'd0, cf}, 32'd0);
        chk("rst_OF", {31'd0, of}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        // Inputs are ignored while reset is held.
        a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_hold_S", {24'd0, s}, 32'd0);
        chk("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        model_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_S", {24'd0, s}, 32'd0);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

        lit("sovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        lit("uwrap_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        lit("both_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        lit("cin_ff_00", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        lit("cin_00_00", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        lit("neg_ovf_80_ff", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
        lit("add_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Hold: drop valid and change operands; result must stay put.
        step(8'hDE, 8'hAD, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk("hold_S", {24'd0, s}, 32'h46);
        chk("hold_out_valid", {31'd0, out_valid}, 32'd0);
        // Mid-stream reset between edges clears at once.
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_S", {24'd0, s}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized sweep for both carry-in values, valid mostly high.
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 256; k++) begin
                step(W'($urandom), W'($urandom), c[0], ($urandom_range(0, 7) != 0));
            end
        end
        // Corner operands against the model.
        for (int k = 0; k < 16; k++) begin
            step({k[0], {(W-1){k[1]}}}, {k[2], {(W-1){k[3]}}}, 1'b1, 1'b1);
        end
        step('0, '0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
